// File: rtl/jk_reg_tcore_stepper.sv
// JK register built on T flip-flop cores: an accepted JK command becomes a toggle mask
// that is applied one bit per clock, LSB first, so q only ever changes by one bit per edge.
module jk_reg_tcore_stepper #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_j,
    input  logic [WIDTH-1:0] cmd_k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] step_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_STEP = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] accept_mask;
    logic [WIDTH-1:0] low_bit;
    logic             last_bit;

    // JK-to-T excitation against the current q, and isolation of the lowest pending toggle
    assign accept_mask = (cmd_j & ~q) | (cmd_k & q);
    assign low_bit     = mask & (~mask + WIDTH'(1));
    assign last_bit    = (mask & (mask - WIDTH'(1))) == '0;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state == ST_STEP);
    assign done      = (state == ST_DONE);
    assign qb        = ~q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            q        <= '0;
            mask     <= '0;
            step_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        mask     <= accept_mask;
                        step_cnt <= '0;
                        state    <= (accept_mask == '0) ? ST_DONE : ST_STEP;
                    end
                end
                ST_STEP: begin
                    q        <= q ^ low_bit;
                    mask     <= mask & ~low_bit;
                    step_cnt <= step_cnt + CNT_W'(1);
                    if (last_bit) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_reg_tcore_stepper.sv
// Scoreboard bench for jk_reg_tcore_stepper: each accepted command pushes its expected q sequence,
// which is popped and compared as the DUT steps through the toggles.
module tb_jk_reg_tcore_stepper;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  cmd_j;
    logic [W-1:0]  cmd_k;
    logic [W-1:0]  q;
    logic [W-1:0]  qb;
    logic          busy;
    logic          done;
    logic [CW-1:0] step_cnt;

    logic [W-1:0]  q_model;
    logic [W-1:0]  exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            done_cnt = 0;

    jk_reg_tcore_stepper #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_j(cmd_j), .cmd_k(cmd_k), .q(q), .qb(qb),
        .busy(busy), .done(done), .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [W-1:0] j, input logic [W-1:0] k, input bit noisy, input string nm);
        logic [W-1:0] mask, qn, prev, want;
        int n, waits, d0;
        waits = 0;
        while (cmd_ready !== 1'b1 && waits < 20) begin
            tick();
            waits++;
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s ready_timeout: cmd_ready=%b required 1", nm, cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        cmd_valid = 1'b1;
        cmd_j = j;
        cmd_k = k;
        mask = (j & ~q_model) | (k & q_model);
        n = $countones(mask);
        qn = q_model;
        for (int b = 0; b < W; b++) begin
            if (mask[b]) begin
                qn[b] = ~qn[b];
                exp_q.push_back(qn);
            end
        end
        d0 = done_cnt;
        tick();  // accept edge
        if (noisy) begin
            cmd_j = W'($urandom);
            cmd_k = W'($urandom);
        end else begin
            cmd_valid = 1'b0;
        end
        if (n > 0) begin
            n_cmp++;
            if (busy !== 1'b1 || cmd_ready !== 1'b0 || done !== 1'b0 || q !== q_model) begin
                n_err++;
                $display("FAIL %s accept: busy=%b ready=%b done=%b q=%h required 1 0 0 %h",
                         nm, busy, cmd_ready, done, q, q_model);
            end
        end
        for (int i = 0; i < n; i++) begin
            prev = q;
            tick();
            if (noisy) begin
                cmd_j = W'($urandom);
                cmd_k = W'($urandom);
            end
            want = exp_q.pop_front();
            n_cmp++;
            if (q !== want || step_cnt !== CW'(i + 1)) begin
                n_err++;
                $display("FAIL %s step%0d: q=%h cnt=%0d required q=%h cnt=%0d", nm, i, q, step_cnt, want, i + 1);
            end
            n_cmp++;
            if ($countones(q ^ prev) != 1) begin
                n_err++;
                $display("FAIL %s hamming%0d: q %h->%h changed %0d bits required 1", nm, i, prev, q, $countones(q ^ prev));
            end
        end
        q_model = q_model ^ mask;
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b0 || step_cnt !== CW'(n) || q !== q_model || qb !== ~q_model) begin
            n_err++;
            $display("FAIL %s done_cycle: done=%b busy=%b ready=%b cnt=%0d q=%h qb=%h required 1 0 0 %0d %h %h",
                     nm, done, busy, cmd_ready, step_cnt, q, qb, n, q_model, ~q_model);
        end
        tick();
        cmd_valid = 1'b0;
        n_cmp++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || q !== q_model || step_cnt !== CW'(n)) begin
            n_err++;
            $display("FAIL %s back_idle: done=%b ready=%b busy=%b q=%h cnt=%0d required 0 1 0 %h %0d",
                     nm, done, cmd_ready, busy, q, step_cnt, q_model, n);
        end
        n_cmp++;
        if (done_cnt != d0 + 1) begin
            n_err++;
            $display("FAIL %s done_pulses: got %0d required 1", nm, done_cnt - d0);
        end
        exp_q.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_j = '0;
        cmd_k = '0;
        tick();
        tick();
        n_cmp++;
        if (q !== 8'h00 || qb !== 8'hFF || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || step_cnt !== '0) begin
            n_err++;
            $display("FAIL reset: q=%h qb=%h ready=%b busy=%b done=%b cnt=%0d required 00 ff 1 0 0 0",
                     q, qb, cmd_ready, busy, done, step_cnt);
        end
        rst = 1'b0;
        q_model = '0;
        tick();
    endtask

    task automatic test_set_pattern;
        run_cmd(8'hA5, 8'h00, 1'b0, "set_a5");
        n_cmp++;
        if (q !== 8'hA5) begin
            n_err++;
            $display("FAIL set_a5_final: q=%h required a5", q);
        end
    endtask

    task automatic test_toggle_all;
        run_cmd(8'hFF, 8'hFF, 1'b0, "toggle_all");
        n_cmp++;
        if (q !== 8'h5A || qb !== 8'hA5 || step_cnt !== CW'(8)) begin
            n_err++;
            $display("FAIL toggle_all_final: q=%h qb=%h cnt=%0d required 5a a5 8", q, qb, step_cnt);
        end
    endtask

    task automatic test_mixed_and_zero;
        run_cmd(8'h0F, 8'hF0, 1'b0, "mixed");
        n_cmp++;
        if (q !== 8'h0F || step_cnt !== CW'(4)) begin
            n_err++;
            $display("FAIL mixed_final: q=%h cnt=%0d required 0f 4", q, step_cnt);
        end
        run_cmd(8'h0F, 8'hF0, 1'b0, "zero_mask");
        n_cmp++;
        if (q !== 8'h0F || step_cnt !== '0) begin
            n_err++;
            $display("FAIL zero_mask_final: q=%h cnt=%0d required 0f 0", q, step_cnt);
        end
    endtask

    task automatic test_back_to_back;
        run_cmd(8'h3C, 8'hC3, 1'b1, "b2b_0");
        run_cmd(8'h81, 8'h7E, 1'b1, "b2b_1");
        run_cmd(8'h00, 8'hFF, 1'b1, "b2b_2");
        for (int i = 0; i < 4; i++) begin
            run_cmd(W'($urandom), W'($urandom), 1'b1, "b2b_rand");
        end
    endtask

    task automatic test_reset_mid;
        int d0;
        run_cmd(8'hF0, 8'h0F, 1'b0, "mid_setup");
        cmd_valid = 1'b1;
        cmd_j = 8'h0F;
        cmd_k = 8'h00;
        tick();  // accept, mask 0x0F
        cmd_valid = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (q !== 8'hF3 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_partial: q=%h busy=%b required f3 1", q, busy);
        end
        d0 = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (q !== 8'h00 || busy !== 1'b0 || cmd_ready !== 1'b1 || step_cnt !== '0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: q=%h busy=%b ready=%b cnt=%0d done=%b required 00 0 1 0 0",
                     q, busy, cmd_ready, step_cnt, done);
        end
        q_model = '0;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if (done_cnt != d0 || q !== 8'h00) begin
            n_err++;
            $display("FAIL mid_no_done: pulses=%0d q=%h required 0 00", done_cnt - d0, q);
        end
        run_cmd(8'h12, 8'h00, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_set_pattern();
        test_toggle_all();
        test_mixed_and_zero();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
